// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of a multiplexed seven-segment display bus.
// Snoops the seg/anode lines of a scan driver, recovers the hex value and
// decimal point of each digit slot, and presents a complete frame of
// NUM_DIGITS nibbles together with a one-cycle frame_valid strobe.
//
// Optional feature: define SEG_CAP_TIMEOUT_EN to build the idle-bus watchdog.
// The watchdog drives 'stale' and discards a partial frame after TIMEOUT_CYC
// cycles without a capture. Without the macro, 'stale' is tied low and a
// partial frame is kept until it completes.

module seg_scan_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYC     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int TIMEOUT_CYC    = 2**20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    an_err,
    output logic                    stale
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    // The settle counter starts at 1 when a new bus value is latched, so
    // SETTLE_CYC stable cycles have elapsed once it reaches SETTLE_CYC-1
    // and the FSM moves on to CAPTURE.
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    logic [7:0]            seg_meta;
    logic [7:0]            seg_sync;
    logic [NUM_DIGITS-1:0] an_meta;
    logic [NUM_DIGITS-1:0] an_sync;

    logic [7:0]            seg_norm;
    logic [NUM_DIGITS-1:0] an_norm;
    logic                  multi_hot;
    logic                  one_hot;
    logic                  multi_hot_q;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [NUM_DIGITS-1:0] cur_an;
    logic [NUM_DIGITS-1:0] cur_an_next;
    logic [7:0]            cur_seg;
    logic [7:0]            cur_seg_next;
    logic                  capture_en;

    logic [3:0]            dec_nib;
    logic                  dec_err;
    logic [IW-1:0]         slot_idx;

    logic [4*NUM_DIGITS-1:0] shadow_nib;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   mask_next;
    logic                    frame_fire;
    logic                    wd_clear;

    // Two-flop synchronisers; reset to the bus idle level so that releasing
    // reset never looks like a multi-hot anode or a lit segment pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta <= {8{SEG_ACTIVE_LOW}};
            seg_sync <= {8{SEG_ACTIVE_LOW}};
            an_meta  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            an_sync  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            seg_meta <= seg_in;
            seg_sync <= seg_meta;
            an_meta  <= an_in;
            an_sync  <= an_meta;
        end
    end

    assign seg_norm  = SEG_ACTIVE_LOW ? ~seg_sync : seg_sync;
    assign an_norm   = AN_ACTIVE_LOW  ? ~an_sync  : an_sync;
    assign multi_hot = |(an_norm & (an_norm - NUM_DIGITS'(1)));
    assign one_hot   = (|an_norm) & ~multi_hot;

    // Multi-hot anode error: one pulse on the first cycle of each episode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_hot_q <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            multi_hot_q <= multi_hot;
            an_err      <= multi_hot & ~multi_hot_q;
        end
    end

    // Capture FSM state register together with the latched bus value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_an  <= '0;
            cur_seg <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cur_an  <= cur_an_next;
            cur_seg <= cur_seg_next;
        end
    end

    // Next-state logic: wait for one anode, require a stable bus, capture once, then hold.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        cur_an_next  = cur_an;
        cur_seg_next = cur_seg;
        capture_en   = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_next   = SETTLE;
                    cnt_next     = CW'(1);
                    cur_an_next  = an_norm;
                    cur_seg_next = seg_norm;
                end
            end
            SETTLE: begin
                if ((an_norm == cur_an) && (seg_norm == cur_seg)) begin
                    if (cnt >= CNT_LAST) begin
                        state_next = CAPTURE;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else if (one_hot) begin
                    cnt_next     = CW'(1);
                    cur_an_next  = an_norm;
                    cur_seg_next = seg_norm;
                end else begin
                    state_next = IDLE;
                end
            end
            CAPTURE: begin
                capture_en = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (an_norm != cur_an) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Segment pattern decoder (a..g) to a hex nibble; unknown patterns flag an error.
    always_comb begin
        dec_nib = 4'hF;
        dec_err = 1'b0;
        case (cur_seg[6:0])
            7'h3F:   dec_nib = 4'h0;
            7'h06:   dec_nib = 4'h1;
            7'h5B:   dec_nib = 4'h2;
            7'h4F:   dec_nib = 4'h3;
            7'h66:   dec_nib = 4'h4;
            7'h6D:   dec_nib = 4'h5;
            7'h7D:   dec_nib = 4'h6;
            7'h07:   dec_nib = 4'h7;
            7'h7F:   dec_nib = 4'h8;
            7'h6F:   dec_nib = 4'h9;
            7'h77:   dec_nib = 4'hA;
            7'h7C:   dec_nib = 4'hB;
            7'h39:   dec_nib = 4'hC;
            7'h5E:   dec_nib = 4'hD;
            7'h79:   dec_nib = 4'hE;
            7'h71:   dec_nib = 4'hF;
            default: begin
                dec_nib = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Slot number of the latched (guaranteed one-hot) anode.
    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cur_an[i]) begin
                slot_idx = IW'(i);
            end
        end
    end

    assign frame_fire = &mask;

    // Capture mask: cleared by a completed frame or the watchdog, then the new capture is merged in.
    always_comb begin
        mask_next = mask;
        if (frame_fire || wd_clear) begin
            mask_next = '0;
        end
        if (capture_en) begin
            mask_next[slot_idx] = 1'b1;
        end
    end

    // Shadow slots collect captures; a full mask copies them to the outputs with a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_nib  <= '0;
            shadow_dp   <= '0;
            shadow_err  <= '0;
            mask        <= '0;
            digits_out  <= '0;
            dp_out      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            mask        <= mask_next;
            frame_valid <= frame_fire;
            if (frame_fire) begin
                digits_out <= shadow_nib;
                dp_out     <= shadow_dp;
                digit_err  <= shadow_err;
            end
            if (capture_en) begin
                shadow_nib[{slot_idx, 2'b00} +: 4] <= dec_nib;
                shadow_dp[slot_idx]                <= cur_seg[7];
                shadow_err[slot_idx]               <= dec_err;
            end
        end
    end

`ifdef SEG_CAP_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYC);

    logic [WW-1:0] wd_cnt;
    logic          wd_hit;

    assign wd_hit   = (wd_cnt == WD_LIMIT);
    assign wd_clear = wd_hit;

    // Idle-bus watchdog: counts searching cycles, saturates at the limit, restarts on every capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else begin
            if (state == CAPTURE) begin
                wd_cnt <= '0;
            end else if (((state == IDLE) || (state == SETTLE)) && !wd_hit) begin
                wd_cnt <= wd_cnt + WW'(1);
            end
            if (frame_fire) begin
                stale <= 1'b0;
            end else if (wd_hit) begin
                stale <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign wd_clear       = 1'b0;
    assign stale          = 1'b0;
`endif

endmodule
